alu_seq_exec: RTL
=================

Name: alu_seq_exec

Overview:
- Execution-side consumer of the 5-bit alucontrol code produced by the ALU decoder.
- Performs the operation selected by alucontrol on two 32-bit operands.
- Start/busy/done handshake lets the multicycle datapath stall on long operations.
- Shifts iterate one bit per cycle, so the block has real sequential latency and replaces a combinational barrel shifter in area-limited builds.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.
- SHW, 5, shift-amount width; equals log2(WIDTH).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when busy=0
- alucontrol  input  5  operation code, sampled on accept
- a  input  32  operand A (rs), sampled on accept
- b  input  32  operand B (rt or extended immediate), sampled on accept
- shamt  input  5  shift amount, sampled on accept
- busy  output  1  high from the cycle after accept until done
- done  output  1  one-cycle pulse when result is valid
- result  output  32  operation result, held until the next accept
- zero  output  1  (result == 0), registered alongside result
- illegal  output  1  set with done when alucontrol is not in the code table

Behaviour:
- Code table:
  - 00010 add a+b, wraps, no overflow trap
  - 00110 sub a-b
  - 00000 and
  - 00001 or
  - 00101 xor
  - 00111 slt: signed, result 1 if a<b else 0
  - 00011 lui: {b[15:0],16'h0000}
  - 01110 sll: b<<shamt
  - 01000 srl: b>>shamt, logical
  - 11001 sra: b>>>shamt, arithmetic, sign of b[31] replicated
  - any other code: result=0, illegal=1
- States: IDLE, SHIFT, FIN.
- IDLE:
  - start=1 latches alucontrol, a, b, shamt.
  - Non-shift code → FIN next cycle, result computed from latched operands.
  - Shift code with shamt=0 → FIN, result=b.
  - Shift code with shamt>0 → SHIFT, working register=b, counter=shamt.
- SHIFT:
  - Each cycle shifts the working register by 1 bit in the latched direction/type and decrements the counter.
  - Counter reaching 0 → FIN.
- FIN:
  - done=1 for exactly one cycle; result, zero and illegal are updated and valid in that cycle.
  - Returns to IDLE next cycle.
- busy=1 in SHIFT and FIN; busy=0 in IDLE.
- Latency, start to done:
  - Non-shift ops: 1 cycle (done asserted the cycle after start).
  - Shifts: shamt+1 cycles, 1 for shamt=0, 32 for shamt=31.
- Back-to-back: start in the cycle after done (IDLE again) is accepted; throughput for non-shift ops is 1 op per 2 cycles.
- start while busy=1 is ignored; input changes while busy have no effect.
- result/zero/illegal hold their values between done pulses and are not cleared on the next accept until the new FIN.
- Reset, including mid-shift:
  - Next state is IDLE; counter cleared.
  - busy=0, done=0, result=0, zero=1, illegal=0.
  - Any in-flight op is discarded, with no done pulse.
- Reset and start in the same cycle: reset wins; start is dropped.

Optional Feature:
- Macro ALU_SEQ_BARREL_EN.
- Defined:
  - Shifts are computed combinationally in IDLE and go straight to FIN; all ops have 1-cycle latency.
  - SHIFT state and counter are removed.
- Undefined: iterative shifter as described above.
- Code table, handshake, reset values and illegal behaviour are identical in both builds.

Test Plan:
- Reset for 2 cycles, then release → busy=0, done=0, result=0, zero=1, illegal=0.
- start, alucontrol=00110, a=5, b=5 → done the next cycle; result=0, zero=1, illegal=0, busy=0 afterwards.
- start, alucontrol=11001, b=32'h8000_0000, shamt=4:
  - busy high 4 cycles then done; result=32'hF800_0000.
  - With ALU_SEQ_BARREL_EN: done 1 cycle after start, same result.
- start, alucontrol=00111, a=32'hFFFF_FFFF, b=1 → result=1.
- Same cycle as that slt accept, start pulse repeated while busy → ignored; exactly one done.
- start, alucontrol=01110, b=1, shamt=31; assert reset after 10 cycles → no done; outputs return to reset values. Next start, alucontrol=00011, b=32'h0000_1234 → result=32'h1234_0000.
- start, alucontrol=01111 → done after 1 cycle; illegal=1, result=0, zero=1.
- Following start, alucontrol=00010, a=32'hFFFF_FFFF, b=1 → result=0, zero=1, illegal=0 (wrap).

Source files
------------

// File: rtl/alu_seq_exec.sv
// Sequential ALU executing the 5-bit alucontrol code with a start/busy/done handshake.
// Build option ALU_SEQ_BARREL_EN: define it for single-cycle combinational shifts instead of the bit-serial shifter.
module alu_seq_exec #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam logic [4:0] OP_ADD = 5'b00010;
  localparam logic [4:0] OP_SUB = 5'b00110;
  localparam logic [4:0] OP_AND = 5'b00000;
  localparam logic [4:0] OP_OR  = 5'b00001;
  localparam logic [4:0] OP_XOR = 5'b00101;
  localparam logic [4:0] OP_SLT = 5'b00111;
  localparam logic [4:0] OP_LUI = 5'b00011;
  localparam logic [4:0] OP_SLL = 5'b01110;
  localparam logic [4:0] OP_SRL = 5'b01000;
  localparam logic [4:0] OP_SRA = 5'b11001;

`ifdef ALU_SEQ_BARREL_EN
  typedef enum logic {IDLE, FIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
`endif

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] op_res;
  logic             op_legal;
  logic             fin_load;
  logic [WIDTH-1:0] fin_res;
  logic             fin_ill;

`ifndef ALU_SEQ_BARREL_EN
  logic [4:0]       op_q;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_n;
  logic [SHW-1:0]   cnt;
  logic             shift_go;
`endif

  // Single-cycle result for the code on the inputs at accept time
  always_comb begin
    op_res   = '0;
    op_legal = 1'b1;
    case (alucontrol)
      OP_ADD: op_res = a + b;
      OP_SUB: op_res = a - b;
      OP_AND: op_res = a & b;
      OP_OR:  op_res = a | b;
      OP_XOR: op_res = a ^ b;
      OP_SLT: op_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_LUI: op_res = {b[15:0], 16'h0000};
`ifdef ALU_SEQ_BARREL_EN
      OP_SLL: op_res = b << shamt;
      OP_SRL: op_res = b >> shamt;
      OP_SRA: op_res = $signed(b) >>> shamt;
`else
      // Only reached with shamt == 0; nonzero amounts go through SHIFT
      OP_SLL: op_res = b;
      OP_SRL: op_res = b;
      OP_SRA: op_res = b;
`endif
      default: op_legal = 1'b0;
    endcase
  end

`ifndef ALU_SEQ_BARREL_EN
  always_comb begin
    shift_go = ((alucontrol == OP_SLL) || (alucontrol == OP_SRL) ||
                (alucontrol == OP_SRA)) && (shamt != '0);
    case (op_q)
      OP_SLL:  work_n = work << 1;
      OP_SRA:  work_n = {work[WIDTH-1], work[WIDTH-1:1]};
      default: work_n = work >> 1;
    endcase
  end
`endif

  always_comb begin
    state_n = state;
    busy    = (state != IDLE);
    done    = (state == FIN);
    case (state)
      IDLE: begin
        if (start) begin
`ifdef ALU_SEQ_BARREL_EN
          state_n = FIN;
`else
          state_n = shift_go ? SHIFT : FIN;
`endif
        end
      end
`ifndef ALU_SEQ_BARREL_EN
      SHIFT: begin
        if (cnt == SHW'(1)) state_n = FIN;
      end
`endif
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Result registers load only on the edge that enters FIN, so they hold across a new accept
  always_comb begin
    fin_load = 1'b0;
    fin_res  = op_res;
    fin_ill  = ~op_legal;
`ifdef ALU_SEQ_BARREL_EN
    if (state == IDLE && start) fin_load = 1'b1;
`else
    if (state == IDLE && start && !shift_go) fin_load = 1'b1;
    if (state == SHIFT && cnt == SHW'(1)) begin
      fin_load = 1'b1;
      fin_res  = work_n;
      fin_ill  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      result  <= '0;
      zero    <= 1'b1;
      illegal <= 1'b0;
`ifndef ALU_SEQ_BARREL_EN
      op_q    <= '0;
      work    <= '0;
      cnt     <= '0;
`endif
    end else begin
      state <= state_n;
      if (fin_load) begin
        result  <= fin_res;
        zero    <= (fin_res == '0);
        illegal <= fin_ill;
      end
`ifndef ALU_SEQ_BARREL_EN
      if (state == IDLE && start) begin
        op_q <= alucontrol;
        work <= b;
        cnt  <= shamt;
      end else if (state == SHIFT) begin
        work <= work_n;
        cnt  <= cnt - SHW'(1);
      end
`endif
    end
  end

endmodule
